// File: rtl/lp_xfer_ctl.sv
// ---------------------------------------------------------------------------
// lp_xfer_ctl -- LP20 transfer control sequencer
//
// Runs a print transfer once CSRA decodes a GO command. For each character
// it fetches a byte over the Unibus DMA read port, waits for the printer to
// demand a character, strobes it out, then advances the bus address and
// byte counter. The transfer ends when the two's-complement byte counter
// wraps to zero, on a DMA or demand timeout, or when the printer goes
// offline.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   lpINIT             controller initialize, acts exactly like reset
//   lpECLR             clear the sticky error flags
//   lpCMDGO            GO command pulse from a CSRA write
//   lpERR              CSRA summary error (blocks GO)
//   lpONLINE           printer on line
//   bctrWRITE/barWRITE load BCTR/BAR from lpDATAI while idle
//   lpDATAI[17:0]      register write data
//   dmaREQ/dmaADDR     DMA read request and byte address (= regBAR)
//   dmaACK/dmaTMO      DMA completion / non-existent memory pulses
//   dmaDATA[15:0]      DMA read word
//   lpDEMAND           printer ready for a character
//   lpSTROBE/lpCHAR    character strobe and character to printer
//   lpGO/lpDONE        transfer active / controller idle
//   lpMTE/lpDTE/lpGOE  sticky memory, demand and GO error flags
//   regBAR, regBCTR    bus address register, byte counter
// ---------------------------------------------------------------------------
module lp_xfer_ctl #(
  parameter int DTE_LIMIT = 4096,
  parameter int STB_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lpINIT,
  input  logic        lpECLR,
  input  logic        lpCMDGO,
  input  logic        lpERR,
  input  logic        lpONLINE,
  input  logic        bctrWRITE,
  input  logic        barWRITE,
  input  logic [17:0] lpDATAI,
  output logic        dmaREQ,
  output logic [17:0] dmaADDR,
  input  logic        dmaACK,
  input  logic        dmaTMO,
  input  logic [15:0] dmaDATA,
  input  logic        lpDEMAND,
  output logic        lpSTROBE,
  output logic [7:0]  lpCHAR,
  output logic        lpGO,
  output logic        lpDONE,
  output logic        lpMTE,
  output logic        lpDTE,
  output logic        lpGOE,
  output logic [17:0] regBAR,
  output logic [11:0] regBCTR
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAITDMD,
    STROBE,
    NEXT,
    COMPLETE,
    ABORT
  } state_t;

  // Counter widths cover 0..LIMIT-1 (at least one bit).
  localparam int DMD_W = (DTE_LIMIT > 1) ? $clog2(DTE_LIMIT) : 1;
  localparam int STB_W = (STB_WIDTH > 1) ? $clog2(STB_WIDTH) : 1;
  localparam logic [DMD_W-1:0] DMD_LAST = DMD_W'(DTE_LIMIT - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STB_WIDTH - 1);

  state_t           state;
  logic             dmaReqQ;
  logic             lpStrobeQ;
  logic [DMD_W-1:0] dmdCnt;
  logic [STB_W-1:0] stbCnt;
  logic [11:0]      bctrNext;

  assign bctrNext = regBCTR + 12'd1;
  assign dmaADDR  = regBAR;

  // The bus request and printer strobe must drop in the same cycle INIT
  // arrives, not one edge later, so the registered values are gated here.
  assign dmaREQ   = dmaReqQ & ~lpINIT;
  assign lpSTROBE = lpStrobeQ & ~lpINIT;

  // NOTE: all state in this block uses non-blocking assignments so every
  // register samples the pre-edge values; later assignments in the same
  // cycle override earlier ones, which is how error set beats lpECLR below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dmaReqQ   <= 1'b0;
      lpStrobeQ <= 1'b0;
      dmdCnt    <= '0;
      stbCnt    <= '0;
      lpCHAR    <= 8'h00;
      lpGO      <= 1'b0;
      lpDONE    <= 1'b1;
      lpMTE     <= 1'b0;
      lpDTE     <= 1'b0;
      lpGOE     <= 1'b0;
      regBAR    <= 18'd0;
      regBCTR   <= 12'd0;
    end else if (lpINIT) begin
      state     <= IDLE;
      dmaReqQ   <= 1'b0;
      lpStrobeQ <= 1'b0;
      dmdCnt    <= '0;
      stbCnt    <= '0;
      lpCHAR    <= 8'h00;
      lpGO      <= 1'b0;
      lpDONE    <= 1'b1;
      lpMTE     <= 1'b0;
      lpDTE     <= 1'b0;
      lpGOE     <= 1'b0;
      regBAR    <= 18'd0;
      regBCTR   <= 12'd0;
    end else begin
      // Clear first; any error set further down in this cycle wins.
      if (lpECLR) begin
        lpMTE <= 1'b0;
        lpDTE <= 1'b0;
        lpGOE <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (barWRITE)  regBAR  <= lpDATAI;
          if (bctrWRITE) regBCTR <= lpDATAI[11:0];
          if (lpCMDGO) begin
            if (lpONLINE && !lpERR) begin
              lpGO    <= 1'b1;
              lpDONE  <= 1'b0;
              dmaReqQ <= 1'b1;
              state   <= FETCH;
            end else begin
              lpGOE <= 1'b1;
            end
          end
        end

        FETCH: begin
          if (dmaTMO) begin
            lpMTE   <= 1'b1;
            dmaReqQ <= 1'b0;
            state   <= ABORT;
          end else if (!lpONLINE) begin
            dmaReqQ <= 1'b0;
            state   <= ABORT;
          end else if (dmaACK) begin
            // Odd byte addresses take the high byte of the word.
            lpCHAR  <= regBAR[0] ? dmaDATA[15:8] : dmaDATA[7:0];
            dmaReqQ <= 1'b0;
            dmdCnt  <= '0;
            state   <= WAITDMD;
          end
        end

        WAITDMD: begin
          if (!lpONLINE) begin
            state <= ABORT;
          end else if (lpDEMAND) begin
            lpStrobeQ <= 1'b1;
            stbCnt    <= '0;
            state     <= STROBE;
          end else if (dmdCnt == DMD_LAST) begin
            lpDTE <= 1'b1;
            state <= ABORT;
          end else begin
            dmdCnt <= dmdCnt + DMD_W'(1);
          end
        end

        STROBE: begin
          if (stbCnt == STB_LAST) begin
            lpStrobeQ <= 1'b0;
            state     <= NEXT;
          end else begin
            stbCnt <= stbCnt + STB_W'(1);
          end
        end

        NEXT: begin
          regBAR  <= regBAR + 18'd1;
          regBCTR <= bctrNext;
          if (bctrNext == 12'd0) begin
            state <= COMPLETE;
          end else begin
            dmaReqQ <= 1'b1;
            state   <= FETCH;
          end
        end

        COMPLETE, ABORT: begin
          lpGO   <= 1'b0;
          lpDONE <= 1'b1;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lp_xfer_ctl.sv
// ---------------------------------------------------------------------------
// tb_lp_xfer_ctl -- directed self-checking bench for lp_xfer_ctl
// Built with DTE_LIMIT=16, STB_WIDTH=4. Inputs change and outputs are
// sampled 1 ns after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_lp_xfer_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        lpINIT, lpECLR, lpCMDGO, lpERR, lpONLINE;
  logic        bctrWRITE, barWRITE;
  logic [17:0] lpDATAI;
  logic        dmaREQ;
  logic [17:0] dmaADDR;
  logic        dmaACK, dmaTMO;
  logic [15:0] dmaDATA;
  logic        lpDEMAND;
  logic        lpSTROBE;
  logic [7:0]  lpCHAR;
  logic        lpGO, lpDONE, lpMTE, lpDTE, lpGOE;
  logic [17:0] regBAR;
  logic [11:0] regBCTR;

  int nVec = 0;
  int nMis = 0;

  lp_xfer_ctl #(.DTE_LIMIT(16), .STB_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .lpINIT(lpINIT), .lpECLR(lpECLR),
    .lpCMDGO(lpCMDGO), .lpERR(lpERR), .lpONLINE(lpONLINE),
    .bctrWRITE(bctrWRITE), .barWRITE(barWRITE), .lpDATAI(lpDATAI),
    .dmaREQ(dmaREQ), .dmaADDR(dmaADDR), .dmaACK(dmaACK), .dmaTMO(dmaTMO),
    .dmaDATA(dmaDATA), .lpDEMAND(lpDEMAND), .lpSTROBE(lpSTROBE),
    .lpCHAR(lpCHAR), .lpGO(lpGO), .lpDONE(lpDONE), .lpMTE(lpMTE),
    .lpDTE(lpDTE), .lpGOE(lpGOE), .regBAR(regBAR), .regBCTR(regBCTR)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nMis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [17:0] bar, input logic [11:0] bctr);
    barWRITE = 1'b1; lpDATAI = bar;          tick();
    barWRITE = 1'b0; bctrWRITE = 1'b1; lpDATAI = {6'd0, bctr}; tick();
    bctrWRITE = 1'b0; lpDATAI = 18'd0;
  endtask

  task automatic go();
    lpCMDGO = 1'b1; tick(); lpCMDGO = 1'b0;
  endtask

  // Wait for a DMA request, check its address, then answer after dly
  // cycles. mode 0: ACK, 1: TMO, 2: ACK and TMO together.
  task automatic serve(input string tag, input logic [15:0] word,
                       input int dly, input int mode,
                       input logic [17:0] expAddr);
    int n;
    n = 0;
    while (!dmaREQ && n < 20) begin tick(); n++; end
    if (!dmaREQ) begin
      check({tag, "_req"}, {31'd0, dmaREQ}, 32'd1);
      return;
    end
    check({tag, "_addr"}, {14'd0, dmaADDR}, {14'd0, expAddr});
    repeat (dly) tick();
    dmaDATA = word;
    dmaACK  = (mode != 1);
    dmaTMO  = (mode != 0);
    tick();
    dmaACK = 1'b0;
    dmaTMO = 1'b0;
  endtask

  // Count cycles of the next strobe pulse; returns once it falls.
  task automatic strobes(output int n);
    int g;
    g = 0;
    n = 0;
    while (g < 30) begin
      if (lpSTROBE) n++;
      else if (n > 0) break;
      tick();
      g++;
    end
  endtask

  int n;
  int pulses, guard;
  logic prevStb;

  initial begin
    rst = 1'b1; lpINIT = 0; lpECLR = 0; lpCMDGO = 0; lpERR = 0;
    lpONLINE = 1; bctrWRITE = 0; barWRITE = 0; lpDATAI = 0;
    dmaACK = 0; dmaTMO = 0; dmaDATA = 0; lpDEMAND = 1;
    #12;
    check("rst_go",     {31'd0, lpGO},     32'd0);
    check("rst_done",   {31'd0, lpDONE},   32'd1);
    check("rst_err",    {29'd0, lpMTE, lpDTE, lpGOE}, 32'd0);
    check("rst_req",    {31'd0, dmaREQ},   32'd0);
    check("rst_stb",    {31'd0, lpSTROBE}, 32'd0);
    check("rst_char",   {24'd0, lpCHAR},   32'd0);
    check("rst_bar",    {14'd0, regBAR},   32'd0);
    check("rst_bctr",   {20'd0, regBCTR},  32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // ---- normal 3-byte transfer from 0o1000 ----
    load(18'o1000, 12'hFFD);
    check("ld_bar",  {14'd0, regBAR},  32'h200);
    check("ld_bctr", {20'd0, regBCTR}, 32'hFFD);
    go();
    check("go_go",   {31'd0, lpGO},   32'd1);
    check("go_req",  {31'd0, dmaREQ}, 32'd1);
    check("go_done", {31'd0, lpDONE}, 32'd0);
    serve("n0", 16'h4241, 2, 0, 18'h200);
    check("n0_char", {24'd0, lpCHAR}, 32'h41);
    check("n0_reqoff", {31'd0, dmaREQ}, 32'd0);
    strobes(n); check("n0_stbw", n, 4);
    serve("n1", 16'h4241, 2, 0, 18'h201);
    check("n1_char", {24'd0, lpCHAR}, 32'h42);
    strobes(n); check("n1_stbw", n, 4);
    serve("n2", 16'h4443, 2, 0, 18'h202);
    check("n2_char", {24'd0, lpCHAR}, 32'h43);
    strobes(n); check("n2_stbw", n, 4);
    tick();
    check("n_go_k", {31'd0, lpGO}, 32'd1);
    tick();
    check("n_go_end",   {31'd0, lpGO},     32'd0);
    check("n_done_end", {31'd0, lpDONE},   32'd1);
    check("n_bar_end",  {14'd0, regBAR},   32'h203);
    check("n_bctr_end", {20'd0, regBCTR},  32'h000);

    // ---- GO rejected: offline, then lpERR ----
    lpONLINE = 1'b0;
    go();
    check("off_goe",  {31'd0, lpGOE},  32'd1);
    check("off_go",   {31'd0, lpGO},   32'd0);
    check("off_done", {31'd0, lpDONE}, 32'd1);
    tick(); tick();
    check("off_go2",  {31'd0, lpGO},   32'd0);
    check("off_req2", {31'd0, dmaREQ}, 32'd0);
    lpECLR = 1'b1; tick(); lpECLR = 1'b0;
    check("off_eclr", {31'd0, lpGOE}, 32'd0);
    lpONLINE = 1'b1; lpERR = 1'b1;
    lpECLR = 1'b1; go(); lpECLR = 1'b0;   // set wins over clear
    check("err_goe",  {31'd0, lpGOE},  32'd1);
    check("err_go",   {31'd0, lpGO},   32'd0);
    check("err_req",  {31'd0, dmaREQ}, 32'd0);
    lpERR = 1'b0;
    lpECLR = 1'b1; tick(); lpECLR = 1'b0;
    check("err_eclr", {31'd0, lpGOE}, 32'd0);

    // ---- memory timeout on second fetch ----
    load(18'h010, 12'hFFC);
    go();
    serve("m0", 16'h1234, 0, 0, 18'h010);
    check("m0_char", {24'd0, lpCHAR}, 32'h34);
    strobes(n); check("m0_stbw", n, 4);
    serve("m1", 16'h5678, 1, 1, 18'h011);
    check("m1_mte", {31'd0, lpMTE},  32'd1);
    check("m1_req", {31'd0, dmaREQ}, 32'd0);
    tick();
    check("m1_done", {31'd0, lpDONE},  32'd1);
    check("m1_go",   {31'd0, lpGO},    32'd0);
    check("m1_bar",  {14'd0, regBAR},  32'h011);
    check("m1_bctr", {20'd0, regBCTR}, 32'hFFD);
    check("m1_char", {24'd0, lpCHAR},  32'h34);
    lpECLR = 1'b1; tick(); lpECLR = 1'b0;
    check("m1_eclr", {31'd0, lpMTE}, 32'd0);
    load(18'h020, 12'hFFF);
    go();
    serve("mb", 16'h9999, 0, 2, 18'h020);
    check("mb_mte",  {31'd0, lpMTE},  32'd1);
    check("mb_char", {24'd0, lpCHAR}, 32'h34);
    tick();
    check("mb_done", {31'd0, lpDONE},   32'd1);
    check("mb_stb",  {31'd0, lpSTROBE}, 32'd0);
    check("mb_bar",  {14'd0, regBAR},   32'h020);
    lpECLR = 1'b1; tick(); lpECLR = 1'b0;

    // ---- demand timeout ----
    lpDEMAND = 1'b0;
    load(18'h000, 12'hFFF);
    go();
    serve("d0", 16'h0011, 0, 0, 18'h000);
    repeat (15) tick();
    check("d0_dte15", {31'd0, lpDTE}, 32'd0);
    tick();
    check("d0_dte16", {31'd0, lpDTE},    32'd1);
    check("d0_stb",   {31'd0, lpSTROBE}, 32'd0);
    tick();
    check("d0_done", {31'd0, lpDONE},  32'd1);
    check("d0_bctr", {20'd0, regBCTR}, 32'hFFF);
    lpECLR = 1'b1; tick(); lpECLR = 1'b0;
    check("d0_eclr", {31'd0, lpDTE}, 32'd0);
    go();
    serve("d1", 16'h0022, 0, 0, 18'h000);
    repeat (15) tick();
    lpDEMAND = 1'b1;
    tick();
    check("d1_dte", {31'd0, lpDTE},    32'd0);
    check("d1_stb", {31'd0, lpSTROBE}, 32'd1);
    strobes(n); check("d1_stbw", n, 4);
    tick(); tick();
    check("d1_done", {31'd0, lpDONE},  32'd1);
    check("d1_bctr", {20'd0, regBCTR}, 32'h000);
    check("d1_dte2", {31'd0, lpDTE},   32'd0);

    // ---- lpINIT during STROBE ----
    load(18'h055, 12'hFF0);
    go();
    serve("i0", 16'hBEEF, 0, 0, 18'h055);
    check("i0_char", {24'd0, lpCHAR}, 32'hBE);
    tick();
    check("i0_stb", {31'd0, lpSTROBE}, 32'd1);
    tick();
    lpINIT = 1'b1; #1;
    check("i0_stb_now", {31'd0, lpSTROBE}, 32'd0);
    tick(); lpINIT = 1'b0;
    check("i0_stb_e", {31'd0, lpSTROBE}, 32'd0);
    check("i0_go",    {31'd0, lpGO},     32'd0);
    check("i0_done",  {31'd0, lpDONE},   32'd1);
    check("i0_bar",   {14'd0, regBAR},   32'h0);
    check("i0_bctr",  {20'd0, regBCTR},  32'h0);
    load(18'h001, 12'hFFF);
    go();
    check("i1_go", {31'd0, lpGO}, 32'd1);
    serve("i1", 16'hABCD, 0, 0, 18'h001);
    check("i1_char", {24'd0, lpCHAR}, 32'hAB);
    strobes(n); check("i1_stbw", n, 4);
    tick(); tick();
    check("i1_done", {31'd0, lpDONE}, 32'd1);
    check("i1_bar",  {14'd0, regBAR}, 32'h002);

    // ---- BCTR=0: 4096-character transfer ----
    load(18'h000, 12'h000);
    go();
    bctrWRITE = 1'b1; barWRITE = 1'b1; lpDATAI = 18'h30123;
    tick();
    bctrWRITE = 1'b0; barWRITE = 1'b0; lpDATAI = 18'd0;
    check("z_bctr_ign", {20'd0, regBCTR}, 32'h000);
    check("z_bar_ign",  {14'd0, regBAR},  32'h000);
    pulses = 0; guard = 0; prevStb = 1'b0; dmaDATA = 16'h0000;
    while (!lpDONE && guard < 40000) begin
      if (lpSTROBE && !prevStb) pulses++;
      prevStb = lpSTROBE;
      dmaACK = dmaREQ;
      tick();
      guard++;
    end
    dmaACK = 1'b0;
    check("z_bounded", {31'd0, lpDONE}, 32'd1);
    check("z_pulses",  pulses, 4096);
    check("z_bar",     {14'd0, regBAR},  32'h01000);
    check("z_bctr",    {20'd0, regBCTR}, 32'h000);
    check("z_go",      {31'd0, lpGO},    32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
